// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: signal bundle between the two requesters, the arbiter and
// the shared 32-bit memory port.
//   Requester side : req0/1, rw0/1 (1 = read), addr0/1, wdata0/1 in;
//                    gnt0/1, ack0/1, rdata, busy out.
//   Memory side    : mem_address, mem_datao, mem_rw (1 = read) out; mem_data in.
// Modport slave is the arbiter's view. Modport master is the view of whoever
// drives the requests and models the memory.
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              rw0;
  logic              rw1;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datao;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_data;
  logic              busy;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_data,
    output gnt0, gnt1, ack0, ack1, rdata, mem_address, mem_datao, mem_rw, busy
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_data,
    input  gnt0, gnt1, ack0, ack1, rdata, mem_address, mem_datao, mem_rw, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer for one 32-bit memory port
// shared by two requesters (0 = CPU bus, 1 = loader/DMA).
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (requests, grants, acks, read data, memory port)
// Each transaction is IDLE (arbitrate) -> ACCESS for MEM_LAT cycles -> DONE
// (ack pulse), so one transaction completes every MEM_LAT+2 cycles.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_cfg_err
    $error("mem_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_LD = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        take;      // some request is pending
  logic        win;       // requester that would be granted this cycle
  logic        sel;       // owner of the current transaction
  logic        last;      // owner of the previous completed transaction
  logic [3:0]  cnt;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic        rw_l;
  logic [31:0] rdata_q;
  logic        active;

  // On a tie the requester that did not finish last wins; a lone request
  // simply wins.
  always_comb begin
    take = bus.req0 | bus.req1;
    win  = (bus.req0 & bus.req1) ? ~last : bus.req1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control and read-data registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sel     <= 1'b0;
      last    <= 1'b1;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            sel <= win;
            cnt <= LAT_LD;
          end
        end
        ACCESS: begin
          if (cnt == 4'd1) begin
            if (rw_l) rdata_q <= bus.mem_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    last <= sel;
        default: ;
      endcase
    end
  end

  // Transaction attributes are captured only on the grant edge, so later
  // changes on the requester inputs cannot disturb an access in flight.
  always_ff @(posedge clock) begin
    if (state == IDLE && take) begin
      addr_l  <= win ? bus.addr1  : bus.addr0;
      wdata_l <= win ? bus.wdata1 : bus.wdata0;
      rw_l    <= win ? bus.rw1    : bus.rw0;
    end
  end

  // ACCESS and DONE are exactly the non-IDLE states.
  assign active          = (state != IDLE);
  assign bus.busy        = active;
  assign bus.gnt0        = active & ~sel;
  assign bus.gnt1        = active &  sel;
  assign bus.ack0        = (state == DONE) & ~sel;
  assign bus.ack1        = (state == DONE) &  sel;
  assign bus.rdata       = rdata_q;
  assign bus.mem_address = active ? addr_l : 32'd0;
  assign bus.mem_datao   = (active && !rw_l) ? wdata_l : 32'd0;
  assign bus.mem_rw      = active ? rw_l : 1'b1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Three instances with
// MEM_LAT = 1, 3 and 4 share one clock; each has its own reset and a
// combinational memory model on its port.
module tb_mem_arbiter;

  localparam logic [31:0] D   = 32'hDEADBEEF;
  localparam logic [31:0] R24 = 32'h5A5A0024;
  localparam logic [31:0] R40 = 32'h5A5A0040;
  localparam int          NV  = 31;

  logic clock;
  logic rst1;
  logic rst3;
  logic rst4;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if b1 ();
  mem_arbiter_if b3 ();
  mem_arbiter_if b4 ();

  mem_arbiter #(.MEM_LAT(1)) u_lat1 (.clock(clock), .reset(rst1), .bus(b1.slave));
  mem_arbiter #(.MEM_LAT(3)) u_lat3 (.clock(clock), .reset(rst3), .bus(b3.slave));
  mem_arbiter #(.MEM_LAT(4)) u_lat4 (.clock(clock), .reset(rst4), .bus(b4.slave));

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
  endfunction

  assign b1.mem_data = mem_model(b1.mem_address);
  assign b3.mem_data = mem_model(b3.mem_address);
  assign b4.mem_data = mem_model(b4.mem_address);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        req0;
    logic        req1;
    logic [31:0] addr0;
    logic [3:0]  ctl;    // {gnt0, gnt1, ack0, ack1}
    logic [31:0] rdata;
    logic [31:0] maddr;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input logic r0, input logic r1, input logic [31:0] a0,
                              input logic [3:0] ctl, input logic [31:0] rd,
                              input logic [31:0] ma);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.addr0 = a0; v.ctl = ctl; v.rdata = rd; v.maddr = ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    b1.req0 = 0; b1.req1 = 0; b1.rw0 = 1; b1.rw1 = 1;
    b1.addr0 = 0; b1.addr1 = 32'h24; b1.wdata0 = 32'h0; b1.wdata1 = 32'h0;
    b3.req0 = 0; b3.req1 = 0; b3.rw0 = 1; b3.rw1 = 1;
    b3.addr0 = 0; b3.addr1 = 0; b3.wdata0 = 0; b3.wdata1 = 0;
    b4.req0 = 0; b4.req1 = 0; b4.rw0 = 1; b4.rw1 = 1;
    b4.addr0 = 0; b4.addr1 = 0; b4.wdata0 = 0; b4.wdata1 = 0;

    // Idle bus, then contention, single read, request drop (MEM_LAT=1)
    for (int i = 0; i < 10; i++) vt[i] = mk(0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
    vt[10] = mk(1, 1, 32'h10, 4'b0000, 32'h0, 32'h0);
    vt[11] = mk(1, 1, 32'h10, 4'b1000, 32'h0, 32'h10);
    vt[12] = mk(1, 1, 32'h10, 4'b1010, D,     32'h10);
    vt[13] = mk(1, 1, 32'h10, 4'b0000, D,     32'h0);
    vt[14] = mk(1, 1, 32'h10, 4'b0100, D,     32'h24);
    vt[15] = mk(1, 1, 32'h10, 4'b0101, R24,   32'h24);
    vt[16] = mk(1, 1, 32'h10, 4'b0000, R24,   32'h0);
    vt[17] = mk(1, 1, 32'h10, 4'b1000, R24,   32'h10);
    vt[18] = mk(1, 1, 32'h10, 4'b1010, D,     32'h10);
    vt[19] = mk(1, 1, 32'h10, 4'b0000, D,     32'h0);
    vt[20] = mk(1, 1, 32'h10, 4'b0100, D,     32'h24);
    vt[21] = mk(0, 0, 32'h10, 4'b0101, R24,   32'h24);
    vt[22] = mk(0, 0, 32'h10, 4'b0000, R24,   32'h0);
    vt[23] = mk(1, 0, 32'h10, 4'b0000, R24,   32'h0);
    vt[24] = mk(0, 0, 32'h10, 4'b1000, R24,   32'h10);
    vt[25] = mk(0, 0, 32'h10, 4'b1010, D,     32'h10);
    vt[26] = mk(0, 0, 32'h10, 4'b0000, D,     32'h0);
    vt[27] = mk(1, 0, 32'h40, 4'b0000, D,     32'h0);
    vt[28] = mk(0, 0, 32'h99, 4'b1000, D,     32'h40);
    vt[29] = mk(0, 0, 32'h99, 4'b1010, R40,   32'h40);
    vt[30] = mk(0, 0, 32'h99, 4'b0000, R40,   32'h0);

    repeat (2) tick();
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    @(negedge clock);
    chk("rst busy1",  32'(b1.busy), 32'h0);
    chk("rst ctl1",   32'({b1.gnt0, b1.gnt1, b1.ack0, b1.ack1}), 32'h0);
    chk("rst rdata1", b1.rdata, 32'h0);
    chk("rst addr1",  b1.mem_address, 32'h0);
    chk("rst datao1", b1.mem_datao, 32'h0);
    chk("rst rw1",    32'(b1.mem_rw), 32'h1);
    chk("rst busy3",  32'(b3.busy), 32'h0);
    chk("rst rw4",    32'(b4.mem_rw), 32'h1);

    for (int i = 0; i < NV; i++) begin
      tick();
      b1.req0  = vt[i].req0;
      b1.req1  = vt[i].req1;
      b1.addr0 = vt[i].addr0;
      @(negedge clock);
      chk($sformatf("v%0d ctl", i), 32'({b1.gnt0, b1.gnt1, b1.ack0, b1.ack1}), 32'(vt[i].ctl));
      chk($sformatf("v%0d busy", i), 32'(b1.busy), 32'(vt[i].ctl[3] | vt[i].ctl[2]));
      chk($sformatf("v%0d rdata", i), b1.rdata, vt[i].rdata);
      chk($sformatf("v%0d maddr", i), b1.mem_address, vt[i].maddr);
      chk($sformatf("v%0d mrw", i), 32'(b1.mem_rw), 32'h1);
      chk($sformatf("v%0d datao", i), b1.mem_datao, 32'h0);
    end

    // MEM_LAT=3: a read to load rdata, then a write that must leave it alone
    tick(); b3.req0 = 1; b3.rw0 = 1; b3.addr0 = 32'h10;
    @(negedge clock);
    tick(); b3.req0 = 0;
    @(negedge clock);
    chk("l3 rd gnt0", 32'(b3.gnt0), 32'h1);
    repeat (2) tick();
    tick(); @(negedge clock);
    chk("l3 rd ack0",  32'(b3.ack0), 32'h1);
    chk("l3 rd rdata", b3.rdata, D);
    tick(); @(negedge clock);
    chk("l3 rd idle", 32'(b3.busy), 32'h0);

    tick(); b3.req1 = 1; b3.rw1 = 0; b3.addr1 = 32'h20; b3.wdata1 = 32'h1234;
    @(negedge clock);
    for (int c = 1; c <= 4; c++) begin
      tick();
      b3.req1 = 0;
      if (c == 2) begin
        b3.wdata1 = 32'hFFFF; b3.rw1 = 1; b3.addr1 = 32'h77;
      end
      @(negedge clock);
      chk($sformatf("l3 wr c%0d mrw", c),   32'(b3.mem_rw), 32'h0);
      chk($sformatf("l3 wr c%0d datao", c), b3.mem_datao, 32'h1234);
      chk($sformatf("l3 wr c%0d maddr", c), b3.mem_address, 32'h20);
      chk($sformatf("l3 wr c%0d gnt", c),   32'({b3.gnt0, b3.gnt1}), 32'h1);
      chk($sformatf("l3 wr c%0d ack", c),   32'({b3.ack0, b3.ack1}), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("l3 wr c%0d rdata", c), b3.rdata, D);
    end
    tick(); @(negedge clock);
    chk("l3 c5 maddr", b3.mem_address, 32'h0);
    chk("l3 c5 datao", b3.mem_datao, 32'h0);
    chk("l3 c5 mrw",   32'(b3.mem_rw), 32'h1);
    chk("l3 c5 busy",  32'(b3.busy), 32'h0);
    chk("l3 c5 rdata", b3.rdata, D);

    // MEM_LAT=4: read by requester 0, then a read aborted by reset
    tick(); b4.req0 = 1; b4.rw0 = 1; b4.addr0 = 32'h10;
    @(negedge clock);
    tick(); b4.req0 = 0;
    repeat (3) tick();
    tick(); @(negedge clock);
    chk("l4 rd ack0",  32'(b4.ack0), 32'h1);
    chk("l4 rd rdata", b4.rdata, D);
    tick(); @(negedge clock);
    chk("l4 rd idle", 32'(b4.busy), 32'h0);

    tick(); b4.req1 = 1; b4.rw1 = 1; b4.addr1 = 32'h24;
    @(negedge clock);
    tick(); b4.req1 = 0;
    @(negedge clock);
    chk("l4 ab gnt1", 32'(b4.gnt1), 32'h1);
    tick(); rst4 = 1'b1;
    @(negedge clock);
    tick(); rst4 = 1'b0;
    @(negedge clock);
    chk("l4 ab busy",  32'(b4.busy), 32'h0);
    chk("l4 ab gnt",   32'({b4.gnt0, b4.gnt1}), 32'h0);
    chk("l4 ab rdata", b4.rdata, 32'h0);
    for (int c = 4; c <= 8; c++) begin
      tick(); @(negedge clock);
      chk($sformatf("l4 ab c%0d ack", c), 32'({b4.ack0, b4.ack1}), 32'h0);
    end

    tick(); b4.req0 = 1; b4.req1 = 1;
    @(negedge clock);
    tick(); b4.req0 = 0; b4.req1 = 0;
    @(negedge clock);
    chk("l4 tie gnt", 32'({b4.gnt0, b4.gnt1}), 32'h2);
    repeat (3) tick();
    tick(); @(negedge clock);
    chk("l4 tie ack",   32'({b4.ack0, b4.ack1}), 32'h2);
    chk("l4 tie rdata", b4.rdata, D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
